// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-source result FIFOs, round-robin grant, one registered RF write per cycle.
// Optional WB_BYPASS_EN: when every FIFO is empty, an incoming result is written directly (1-edge latency).
module writeback_arbiter #(
  parameter int unsigned NUM_SRC   = 3,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_AW    = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]   src_wdata,
  output logic                      rf_wen,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic [NUM_SRC-1:0]        wb_src,
  output logic                      idle
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0][REG_AW-1:0] in_rd;
  logic [NUM_SRC-1:0][XLEN-1:0]   in_data;

  assign in_rd   = src_rd;
  assign in_data = src_wdata;

  logic [REG_AW-1:0] mem_rd_q   [NUM_SRC][BUF_DEPTH];
  logic [XLEN-1:0]   mem_data_q [NUM_SRC][BUF_DEPTH];

  logic [NUM_SRC-1:0][PW-1:0] wptr_q, wptr_d;
  logic [NUM_SRC-1:0][PW-1:0] rptr_q, rptr_d;
  logic [NUM_SRC-1:0][CW-1:0] count_q, count_d;
  logic [SW-1:0]              rr_q, rr_d;

  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               bypass;
  logic               gnt;
  logic [SW-1:0]      gnt_idx;
  logic [REG_AW-1:0]  head_rd;
  logic [XLEN-1:0]    head_data;

  logic               rf_wen_q;
  logic [REG_AW-1:0]  rf_waddr_q;
  logic [XLEN-1:0]    rf_wdata_q;
  logic [NUM_SRC-1:0] wb_src_q;

  // Ready is a pure function of the registered count, never of a same-cycle pop.
  always_comb begin
    src_ready = '0;
    nonempty  = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_ready[i] = count_q[i] < CW'(BUF_DEPTH);
      nonempty[i]  = count_q[i] != '0;
    end
  end

  always_comb begin
    int s;
    req     = nonempty;
    bypass  = 1'b0;
`ifdef WB_BYPASS_EN
    if (nonempty == '0 && !flush) begin
      req    = src_valid & src_ready;
      bypass = 1'b1;
    end
`endif
    gnt     = 1'b0;
    gnt_idx = '0;
    // Walk from the farthest candidate back to rr_q so the closest requester wins.
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      s = int'(rr_q) + k;
      if (s >= int'(NUM_SRC)) s = s - int'(NUM_SRC);
      if (req[SW'(s)]) begin
        gnt     = 1'b1;
        gnt_idx = SW'(s);
      end
    end
    if (bypass) begin
      head_rd   = in_rd[gnt_idx];
      head_data = in_data[gnt_idx];
    end else begin
      head_rd   = mem_rd_q[gnt_idx][rptr_q[gnt_idx]];
      head_data = mem_data_q[gnt_idx][rptr_q[gnt_idx]];
    end
  end

  always_comb begin
    push    = '0;
    pop     = '0;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      push[i] = src_valid[i] & src_ready[i] & ~flush & ~(bypass & gnt & (gnt_idx == SW'(i)));
      pop[i]  = gnt & ~bypass & (gnt_idx == SW'(i));
      if (push[i]) wptr_d[i] = wptr_q[i] + PW'(1);
      if (pop[i])  rptr_d[i] = rptr_q[i] + PW'(1);
      count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (flush) begin
        wptr_d[i]  = '0;
        rptr_d[i]  = '0;
        count_d[i] = '0;
      end
    end
    rr_d = rr_q;
    if (gnt) rr_d = (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + SW'(1);
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (push[i]) begin
        mem_rd_q[i][wptr_q[i]]   <= in_rd[i];
        mem_data_q[i][wptr_q[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rr_q       <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_src_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      if (gnt) begin
        // Writes to x0 are consumed but never reach the register file.
        rf_wen_q   <= head_rd != '0;
        rf_waddr_q <= head_rd;
        rf_wdata_q <= head_data;
        wb_src_q   <= NUM_SRC'(1) << gnt_idx;
      end else begin
        rf_wen_q <= 1'b0;
        wb_src_q <= '0;
      end
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_src   = wb_src_q;
  assign idle     = ~rf_wen_q & (nonempty == '0);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic against a queue-level model.
module tb_writeback_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_rd;
  logic [95:0] src_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  wb_src;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per-source arrays used as FIFOs (index 0 = oldest).
  logic [4:0]  m_rd   [3][2];
  logic [31:0] m_data [3][2];
  int          m_cnt  [3];
  int          m_rr;
  logic        exp_wen;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [2:0]  exp_src;

  writeback_arbiter #(
    .NUM_SRC  (3),
    .BUF_DEPTH(2),
    .XLEN     (32),
    .REG_AW   (5)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (flush),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_rd   (src_rd),
    .src_wdata(src_wdata),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .wb_src   (wb_src),
    .idle     (idle)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_rr      = 0;
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_src   = '0;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    src_valid[i]       = v;
    src_rd[i*5 +: 5]   = rd;
    src_wdata[i*32 +: 32] = d;
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] rdy;
    logic       all_empty;
    all_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = m_cnt[i] < 2;
      if (m_cnt[i] != 0) all_empty = 1'b0;
    end
    chk({tag, ".rf_wen"},    rf_wen,    exp_wen);
    chk({tag, ".wb_src"},    wb_src,    exp_src);
    chk({tag, ".rf_waddr"},  rf_waddr,  exp_waddr);
    chk({tag, ".rf_wdata"},  rf_wdata,  exp_wdata);
    chk({tag, ".src_ready"}, src_ready, rdy);
    chk({tag, ".idle"},      idle,      !exp_wen && all_empty);
  endtask

  // Apply the current inputs to the model for one edge, then clock the DUT and compare.
  task automatic cycle(input string tag);
    int         gi;
    logic       byp;
    logic [2:0] acc;
    logic [4:0] e_rd;
    logic [31:0] e_data;
    int         s;
    gi  = -1;
    byp = 1'b0;
    e_rd = '0;
    e_data = '0;
    for (int k = 0; k < 3; k++) begin
      s = (m_rr + k) % 3;
      if (gi < 0 && m_cnt[s] > 0) gi = s;
    end
`ifdef WB_BYPASS_EN
    if (gi < 0 && !flush) begin
      for (int k = 0; k < 3; k++) begin
        s = (m_rr + k) % 3;
        if (gi < 0 && src_valid[s]) begin
          gi  = s;
          byp = 1'b1;
        end
      end
    end
`endif
    if (gi >= 0) begin
      if (byp) begin
        e_rd   = src_rd[gi*5 +: 5];
        e_data = src_wdata[gi*32 +: 32];
      end else begin
        e_rd   = m_rd[gi][0];
        e_data = m_data[gi][0];
      end
    end
    for (int i = 0; i < 3; i++)
      acc[i] = src_valid[i] && m_cnt[i] < 2 && !flush && !(byp && gi == i);
    if (gi >= 0 && !byp) begin
      m_rd[gi][0]   = m_rd[gi][1];
      m_data[gi][0] = m_data[gi][1];
      m_cnt[gi]--;
    end
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        m_rd[i][m_cnt[i]]   = src_rd[i*5 +: 5];
        m_data[i][m_cnt[i]] = src_wdata[i*32 +: 32];
        m_cnt[i]++;
      end
      if (flush) m_cnt[i] = 0;
    end
    if (gi >= 0) begin
      exp_wen   = e_rd != 0;
      exp_waddr = e_rd;
      exp_wdata = e_data;
      exp_src   = 3'b001 << gi;
      m_rr      = (gi + 1) % 3;
    end else begin
      exp_wen = 1'b0;
      exp_src = '0;
    end
    @(posedge CLK);
    #1;
    check_outputs(tag);
  endtask

  task automatic clear_inputs();
    src_valid = '0;
    src_rd    = '0;
    src_wdata = '0;
    flush     = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // 1: single result from source 0
    set_src(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cycle("t1_accept");
    clear_inputs();
    for (int n = 0; n < 3; n++) cycle("t1_drain");
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'hDEAD_BEEF);

    // 2: all sources continuously valid
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 3; i++) set_src(i, 1'b1, 5'(i + 1), $urandom);
      cycle("t2_stream");
    end
    clear_inputs();
    for (int n = 0; n < 8; n++) cycle("t2_drain");

    // 3: write to x0 from source 1
    set_src(1, 1'b1, 5'd0, 32'h1234);
    cycle("t3_accept");
    clear_inputs();
    for (int n = 0; n < 3; n++) cycle("t3_drain");
    chk("t3_wdata", rf_wdata, 32'h1234);
    chk("t3_waddr", rf_waddr, 0);

    // 4: contention lets FIFO2 fill; src2 data advances only when accepted
    begin
      logic [31:0] seq [3];
      int          idx;
      seq[0] = 32'hAAAA_0001;
      seq[1] = 32'hBBBB_0002;
      seq[2] = 32'hCCCC_0003;
      idx = 0;
      for (int n = 0; n < 10; n++) begin
        set_src(0, 1'b1, 5'd7, $urandom);
        set_src(1, 1'b1, 5'd8, $urandom);
        set_src(2, idx < 3, 5'd9, seq[idx < 3 ? idx : 2]);
        if (idx < 3 && src_ready[2]) idx++;
        cycle("t4_fill");
      end
      clear_inputs();
      for (int n = 0; n < 8; n++) cycle("t4_drain");
    end

    // 5: buffer entries then flush
    set_src(0, 1'b1, 5'd10, 32'h5000_0001);
    set_src(1, 1'b1, 5'd11, 32'h5100_0001);
    set_src(2, 1'b1, 5'd12, 32'h5200_0001);
    cycle("t5_load");
    set_src(0, 1'b1, 5'd10, 32'h5000_0002);
    set_src(2, 1'b0, 5'd0, 32'h0);
    cycle("t5_load");
    clear_inputs();
    flush = 1'b1;
    set_src(0, 1'b1, 5'd13, 32'h5000_0003);
    cycle("t5_flush");
    clear_inputs();
    cycle("t5_after");
    chk("t5_idle", idle, 1'b1);
    chk("t5_ready", src_ready, 3'b111);
    chk("t5_wen", rf_wen, 1'b0);

    // 6: asynchronous reset while FIFOs hold data
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 3; i++) set_src(i, 1'b1, 5'(20 + i), $urandom);
      cycle("t6_load");
    end
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check_outputs("t6_async_reset");
    clear_inputs();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cycle("t6_post");

    // random traffic with occasional flush
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++)
        set_src(i, $urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom);
      flush = $urandom_range(0, 19) == 0;
      cycle("rand");
    end
    clear_inputs();
    for (int n = 0; n < 8; n++) cycle("final_drain");
    chk("final_idle", idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
